// File: rtl/multicore_debug_pkg.sv
// Shared types and default sizing for the multicore debug memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicore_debug_pkg;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_TIMEOUT   = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width of a core index; a single core still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicore_debug_rr_pick.sv
// Round-robin picker: first requester at or after the pointer, wrapping.
// Latency: combinational.
// Backpressure: none; grant is all-zero when no request is present.
// Ports: i_req (request vector), i_ptr (highest-priority index),
//        o_grant (one-hot winner), o_idx (winner index, 0 when none).
module multicore_debug_rr_pick
    import multicore_debug_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    localparam int IDX_W    = idx_w(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_CORES-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx
);

    always_comb begin
        logic found;
        int   j;
        found   = 1'b0;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            j = int'(i_ptr) + k;
            if (j >= NUM_CORES) begin
                j = j - NUM_CORES;
            end
            if (!found && i_req[j]) begin
                found      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/multicore_debug_mem_arbiter.sv
// Arbitrates NUM_CORES debug requesters onto one shared monitor-memory port.
// Latency: accept N, strobe N+1, response N+2 with no wait; +1 per waitrequest cycle.
// Backpressure: one transaction in flight; req_ready only in IDLE; waitrequest stalls up to TIMEOUT cycles.
// Ports: clk/reset; req_valid/req_write/req_addr/req_wdata in, req_ready out (per core);
//        rsp_valid (per core), rsp_rdata, rsp_error out; mem_read/mem_write/mem_addr/mem_wdata out,
//        mem_rdata/mem_waitrequest in.
module multicore_debug_mem_arbiter
    import multicore_debug_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req_valid,
    input  logic [NUM_CORES-1:0]        req_write,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    output logic [NUM_CORES-1:0]        req_ready,
    output logic [NUM_CORES-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_error,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_waitrequest
);

    localparam int IDX_W = idx_w(NUM_CORES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_error;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_CORES-1:0] w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic                 w_accept;

    multicore_debug_rr_pick #(
        .NUM_CORES (NUM_CORES)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_any    = |req_valid;
    assign w_accept = !reset && (r_state == ST_IDLE) && w_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_idx;
                        r_write <= req_write[w_idx];
                        r_addr  <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                        r_wdata <= req_wdata[int'(w_idx)*DATA_W +: DATA_W];
                        r_cnt   <= '0;
                        // Winner drops to lowest priority for the next arbitration.
                        if (w_idx == IDX_W'(NUM_CORES - 1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= w_idx + IDX_W'(1);
                        end
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (!mem_waitrequest) begin
                        // Writes leave the last read data on rsp_rdata.
                        if (!r_write) begin
                            r_rdata <= mem_rdata;
                        end
                        r_error <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Strobe has been stalled for TIMEOUT cycles: abort.
                        r_error <= 1'b1;
                        r_rdata <= '0;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state; reset masks them in the reset cycle itself.
    assign req_ready = w_accept ? w_grant : '0;
    assign mem_read  = !reset && (r_state == ST_BUS) && !r_write;
    assign mem_write = !reset && (r_state == ST_BUS) &&  r_write;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rsp_rdata = reset ? '0 : r_rdata;
    assign rsp_error = !reset && r_error;

    always_comb begin
        rsp_valid = '0;
        if (!reset && (r_state == ST_RESP)) begin
            rsp_valid[r_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_multicore_debug_mem_arbiter.sv
module tb_multicore_debug_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 255;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   req_valid;
    logic [NC-1:0]   req_write;
    logic [NC*AW-1:0] req_addr;
    logic [NC*DW-1:0] req_wdata;
    logic [NC-1:0]   req_ready;
    logic [NC-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_error;
    logic            mem_read;
    logic            mem_write;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_waitrequest;

    int n_cmp = 0;
    int n_mis = 0;

    multicore_debug_mem_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_waitrequest (mem_waitrequest)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first requesting core at or after the pointer, wrapping.
    function automatic int rr_win(input logic [NC-1:0] m, input int p);
        for (int i = 0; i < NC; i++) begin
            if (m[(p + i) % NC]) return (p + i) % NC;
        end
        return -1;
    endfunction

    function automatic logic [NC-1:0] onehot(input int w);
        logic [NC-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    logic [DW-1:0] mem_model [256];
    int            m_ptr;
    logic [DW-1:0] m_last_rd;

    initial begin
        int n_strobe;
        bit seen3;
        reset = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        mem_rdata = '0;
        mem_waitrequest = 1'b0;
        for (int i = 0; i < 256; i++) mem_model[i] = $urandom;

        // Reset: outputs quiet even with every core requesting.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = '1;
            #1;
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_strobes", {mem_read, mem_write}, 0);
            chk("rst_rdata", rsp_rdata, 0);
            chk("rst_error", rsp_error, 0);
        end

        // All cores request continuously: grant order 0,1,2,3,0.
        for (int i = 0; i < NC; i++) req_addr[i*AW +: AW] = AW'(8'h10 + i);
        m_ptr = 0;
        mem_rdata = 32'h1111_2222;
        @(negedge clk);
        reset = 1'b0;
        req_valid = '1;
        #1;
        for (int k = 0; k < 5; k++) begin
            int w;
            w = rr_win(req_valid, m_ptr);
            chk($sformatf("rr_grant_%0d", k), req_ready, onehot(w));
            m_ptr = (w + 1) % NC;
            @(negedge clk); #1;
            chk($sformatf("rr_read_%0d", k), {mem_read, mem_write}, 2'b10);
            chk($sformatf("rr_addr_%0d", k), mem_addr, 8'h10 + w);
            @(negedge clk); #1;
            chk($sformatf("rr_rsp_%0d", k), rsp_valid, onehot(w));
            @(negedge clk);
            if (k == 4) req_valid = '0;
            #1;
        end
        chk("idle_no_ready", req_ready, 0);

        // Single read, core 2, address 0x15.
        @(negedge clk);
        req_valid = 4'b0100;
        req_write = '0;
        req_addr[2*AW +: AW] = 8'h15;
        mem_rdata = 32'hCAFE_0001;
        #1;
        chk("rd_ready", req_ready, 4'b0100);
        chk("rd_no_strobe_n", {mem_read, mem_write}, 0);
        m_ptr = 3;
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rd_strobe", {mem_read, mem_write}, 2'b10);
        chk("rd_addr", mem_addr, 8'h15);
        chk("rd_ready_busy", req_ready, 0);
        @(negedge clk); #1;
        chk("rd_rsp_valid", rsp_valid, 4'b0100);
        chk("rd_rdata", rsp_rdata, 32'hCAFE_0001);
        chk("rd_error", rsp_error, 0);
        chk("rd_no_strobe_resp", {mem_read, mem_write}, 0);
        @(negedge clk); #1;
        chk("rd_rsp_once", rsp_valid, 0);

        // Write, core 1, three waitrequest cycles.
        @(negedge clk);
        req_valid = 4'b0010;
        req_write = 4'b0010;
        req_addr[1*AW +: AW] = 8'h80;
        req_wdata[1*DW +: DW] = 32'h1234_5678;
        mem_waitrequest = 1'b1;
        #1;
        chk("wr_ready", req_ready, 4'b0010);
        m_ptr = 2;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = '0;
            req_addr = '0;
            req_wdata = '0;
            if (c == 3) mem_waitrequest = 1'b0;
            #1;
            chk($sformatf("wr_strobe_%0d", c), {mem_read, mem_write}, 2'b01);
            chk($sformatf("wr_addr_%0d", c), mem_addr, 8'h80);
            chk($sformatf("wr_data_%0d", c), mem_wdata, 32'h1234_5678);
        end
        @(negedge clk); #1;
        chk("wr_rsp_valid", rsp_valid, 4'b0010);
        chk("wr_error", rsp_error, 0);
        chk("wr_rdata_hold", rsp_rdata, 32'hCAFE_0001);
        chk("wr_strobe_off", {mem_read, mem_write}, 0);
        req_write = '0;

        // Waitrequest stuck high: abort after TIMEOUT strobe cycles.
        @(negedge clk);
        req_valid = 4'b1000;
        req_addr[3*AW +: AW] = 8'h42;
        mem_waitrequest = 1'b1;
        #1;
        chk("to_ready", req_ready, 4'b1000);
        m_ptr = 0;
        n_strobe = 0;
        for (int c = 0; c < TO + 40; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (!mem_read) break;
            n_strobe++;
        end
        chk("to_strobe_cycles", n_strobe, TO);
        chk("to_rsp_valid", rsp_valid, 4'b1000);
        chk("to_error", rsp_error, 1);
        chk("to_rdata", rsp_rdata, 0);
        mem_waitrequest = 1'b0;

        // Next request after timeout is served normally.
        @(negedge clk);
        req_valid = 4'b0001;
        mem_rdata = 32'h5A5A_5A5A;
        #1;
        chk("post_to_ready", req_ready, 4'b0001);
        m_ptr = 1;
        @(negedge clk);
        req_valid = '0;
        #1;
        @(negedge clk); #1;
        chk("post_to_rsp", rsp_valid, 4'b0001);
        chk("post_to_error", rsp_error, 0);
        chk("post_to_rdata", rsp_rdata, 32'h5A5A_5A5A);

        // Reset during BUS aborts silently and clears the pointer.
        @(negedge clk);
        req_valid = 4'b0100;
        mem_waitrequest = 1'b1;
        #1;
        chk("rb_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rb_in_bus", mem_read, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rb_strobe_in_reset", {mem_read, mem_write}, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset = 1'b0;
            #1;
            chk($sformatf("rb_strobe_after_%0d", c), {mem_read, mem_write}, 0);
            chk($sformatf("rb_no_rsp_%0d", c), rsp_valid, 0);
        end
        @(negedge clk);
        req_valid = '1;
        mem_waitrequest = 1'b0;
        mem_rdata = 32'h0000_0077;
        #1;
        chk("rb_ptr_zero", req_ready, 4'b0001);
        m_ptr = 1;
        @(negedge clk);
        req_valid = '0;
        #1;
        @(negedge clk); #1;
        chk("rb_rsp", rsp_valid, 4'b0001);
        chk("rb_rdata", rsp_rdata, 32'h0000_0077);

        // Core 3 requests only while core 0 is busy, then withdraws.
        @(negedge clk);
        req_valid = 4'b0001;
        mem_waitrequest = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        #1;
        chk("drop_ready0", req_ready, 4'b0001);
        m_ptr = 1;
        seen3 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = (c < 2) ? 4'b1000 : 4'b0000;
            if (c == 2) mem_waitrequest = 1'b0;
            #1;
            seen3 |= req_ready[3] | rsp_valid[3];
        end
        @(negedge clk); #1;
        chk("drop_rsp0", rsp_valid, 4'b0001);
        chk("drop_rdata0", rsp_rdata, 32'h0BAD_F00D);
        m_last_rd = 32'h0BAD_F00D;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            seen3 |= req_ready[3] | rsp_valid[3] | (|req_ready);
        end
        chk("drop_core3_never", seen3, 0);

        // Randomized traffic against a memory model.
        for (int t = 0; t < 40; t++) begin
            logic [NC-1:0] mask;
            int w, nwait;
            logic          e_wr;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_wdata, e_rd;
            mask = NC'($urandom_range(1, (1 << NC) - 1));
            nwait = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
            @(negedge clk);
            req_valid = mask;
            req_write = NC'($urandom);
            for (int i = 0; i < NC; i++) begin
                req_addr[i*AW +: AW] = AW'($urandom);
                req_wdata[i*DW +: DW] = $urandom;
            end
            mem_waitrequest = (nwait > 0);
            #1;
            w = rr_win(mask, m_ptr);
            e_wr = req_write[w];
            e_addr = req_addr[w*AW +: AW];
            e_wdata = req_wdata[w*DW +: DW];
            chk($sformatf("rnd_grant_%0d", t), req_ready, onehot(w));
            m_ptr = (w + 1) % NC;
            for (int b = 0; b <= nwait; b++) begin
                @(negedge clk);
                req_valid = '0;
                req_addr = AW'($urandom) * NC;
                mem_waitrequest = (b < nwait);
                mem_rdata = mem_model[e_addr];
                #1;
                chk($sformatf("rnd_strobe_%0d", t), {mem_read, mem_write}, {~e_wr, e_wr});
                chk($sformatf("rnd_addr_%0d", t), mem_addr, e_addr);
                if (e_wr) chk($sformatf("rnd_wdata_%0d", t), mem_wdata, e_wdata);
            end
            if (e_wr) begin
                mem_model[e_addr] = e_wdata;
                e_rd = m_last_rd;
            end else begin
                e_rd = mem_model[e_addr];
                m_last_rd = e_rd;
            end
            @(negedge clk);
            mem_waitrequest = 1'b0;
            #1;
            chk($sformatf("rnd_rsp_%0d", t), rsp_valid, onehot(w));
            chk($sformatf("rnd_rdata_%0d", t), rsp_rdata, e_rd);
            chk($sformatf("rnd_error_%0d", t), rsp_error, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
